cache_page_lookup: RTL

- Fully associative page-tag lookup stage directly downstream of the phi2 sequencer.
- On each phi2 rising edge it captures the 24-bit CPU address and compares A[23:10] against 64 page tags.
- It produces the 16-bit cache SRAM address `{slot, A[9:0]}`.
- On a miss it stalls the CPU, requests a page fill from the copy engine through a req/ack handshake, installs the tag round-robin, then completes the access.

---
 rtl/cache_page_lookup.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cache_page_lookup.sv
// cache_page_lookup
//   Fully associative page-tag lookup stage behind the phi2 sequencer. Each
//   qualified phi2 rising edge captures the CPU address, compares its page tag
//   against every cached page and returns the cache SRAM address
//   {slot, offset}. On a miss the CPU is stalled while the copy engine fills
//   the round-robin victim slot; the access then completes as a hit.
//
// Ports
//   fpgaClk      system clock (rising edge)
//   fpgaReset_n  asynchronous active-low reset
//   phi2         CPU phase; the rising edge starts a lookup when addrValid
//   addrValid    address on a is valid for this bus cycle
//   a            extended CPU address {tag, offset}
//   flush        level; invalidates every page (deferred if busy)
//   extAddr      cache SRAM address {slot, offset}, holds between accesses
//   hit          one-cycle pulse, extAddr valid for the current bus cycle
//   stall        CPU hold while a miss is outstanding
//   fillReq      page fill request to the copy engine
//   fillTag      tag of the page to fetch
//   fillSlot     slot being overwritten
//   fillAck      copy engine finished the page
module cache_page_lookup #(
  parameter int NUM_SLOTS = 64,
  parameter int SLOT_W    = 6,
  parameter int TAG_W     = 14,
  parameter int OFS_W     = 10
) (
  input  logic                     fpgaClk,
  input  logic                     fpgaReset_n,
  input  logic                     phi2,
  input  logic                     addrValid,
  input  logic [TAG_W+OFS_W-1:0]   a,
  input  logic                     flush,
  output logic [SLOT_W+OFS_W-1:0]  extAddr,
  output logic                     hit,
  output logic                     stall,
  output logic                     fillReq,
  output logic [TAG_W-1:0]         fillTag,
  output logic [SLOT_W-1:0]        fillSlot,
  input  logic                     fillAck
);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESOLVE,
    MISS
  } state_t;

  state_t state_reg, state_next;

  logic                     phi2_prev_reg;
  logic [TAG_W+OFS_W-1:0]   a_reg;
  logic [NUM_SLOTS-1:0]     valid_reg;
  logic [NUM_SLOTS-1:0]     hv_reg;
  logic [SLOT_W-1:0]        repl_ptr_reg;
  logic                     flush_pend_reg;
  logic [TAG_W-1:0]         tag_mem [NUM_SLOTS];

  logic [NUM_SLOTS-1:0]     match;
  logic [SLOT_W-1:0]        hit_slot;
  logic                     start;
  logic                     flush_now;
  logic                     install;
  logic [TAG_W-1:0]         a_tag;
  logic [OFS_W-1:0]         a_ofs;

  assign a_tag     = a_reg[TAG_W+OFS_W-1:OFS_W];
  assign a_ofs     = a_reg[OFS_W-1:0];
  assign start     = phi2 & ~phi2_prev_reg & addrValid;
  assign flush_now = flush | flush_pend_reg;
  assign install   = (state_reg == MISS) & fillAck;

  // Parallel tag compare against every slot.
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_cmp
      assign match[gi] = valid_reg[gi] & (tag_mem[gi] == a_tag);
    end
  endgenerate

  // Only one bit can be set in practice; lowest index wins regardless.
  always_comb begin
    hit_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hv_reg[i]) hit_slot = SLOT_W'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!flush_now && start) state_next = LOOKUP;
      LOOKUP:  state_next = RESOLVE;
      RESOLVE: state_next = (|hv_reg) ? IDLE : MISS;
      MISS:    if (fillAck) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Tag storage has no reset: entries are only meaningful behind valid_reg.
  always_ff @(posedge fpgaClk) begin
    if (install) tag_mem[repl_ptr_reg] <= fillTag;
  end

  always_ff @(posedge fpgaClk or negedge fpgaReset_n) begin
    if (!fpgaReset_n) begin
      state_reg      <= IDLE;
      phi2_prev_reg  <= 1'b0;
      a_reg          <= '0;
      valid_reg      <= '0;
      hv_reg         <= '0;
      repl_ptr_reg   <= '0;
      flush_pend_reg <= 1'b0;
      extAddr        <= '0;
      hit            <= 1'b0;
      stall          <= 1'b0;
      fillReq        <= 1'b0;
      fillTag        <= '0;
      fillSlot       <= '0;
    end else begin
      state_reg     <= state_next;
      phi2_prev_reg <= phi2;
      hit           <= 1'b0;

      // A flush seen while busy is remembered and applied once back in IDLE.
      if (state_reg != IDLE && flush) flush_pend_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (flush_now) begin
            valid_reg      <= '0;
            repl_ptr_reg   <= '0;
            flush_pend_reg <= 1'b0;
          end else if (start) begin
            a_reg <= a;
          end
        end
        LOOKUP: hv_reg <= match;
        RESOLVE: begin
          if (|hv_reg) begin
            extAddr <= {hit_slot, a_ofs};
            hit     <= 1'b1;
          end else begin
            stall    <= 1'b1;
            fillReq  <= 1'b1;
            fillTag  <= a_tag;
            fillSlot <= repl_ptr_reg;
          end
        end
        MISS: begin
          if (fillAck) begin
            valid_reg[repl_ptr_reg] <= 1'b1;
            extAddr                 <= {repl_ptr_reg, a_ofs};
            hit                     <= 1'b1;
            fillReq                 <= 1'b0;
            stall                   <= 1'b0;
            repl_ptr_reg            <= repl_ptr_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
